ntt_bf_scheduler: RTL and testbench
===================================

Name: ntt_bf_scheduler

Overview:
Sequencing controller on the other end of the radix-2 butterfly datapath. It walks all log2(N) stages of an in-place NTT (Cooley-Tukey, select=0) or INTT (Gentleman-Sande, select=1). Each cycle it issues one butterfly's operand read addresses, twiddle-ROM address and mode. Matching write-back addresses come out after the butterfly pipeline latency, and each stage is drained before the next starts so there is no read-after-write hazard.

Parameters:
N_LOG, 8, log2 of transform length N; all address ports are N_LOG bits.
BF_LAT, 2, cycles from read issue to write-back (memory read + butterfly + register); must be >= 1.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a transform; sampled only in IDLE.
mode_in  input  1  0 = NTT, 1 = INTT; latched with start.
hold  input  1  stall from memory arbiter; freezes all state while high.
busy  output  1  high in RUN, DRAIN, DONE.
done  output  1  one-cycle pulse at completion.
mode_out  output  1  latched mode; drives butterfly select.
rd_valid  output  1  read/issue strobe.
rd_addr_a  output  N_LOG  upper-leg operand address.
rd_addr_b  output  N_LOG  lower-leg operand address.
tw_addr  output  N_LOG  twiddle ROM index.
wr_valid  output  1  write-back strobe.
wr_addr_a  output  N_LOG  write address for butterfly output_1.
wr_addr_b  output  N_LOG  write address for butterfly output_2.

Behaviour:
- Reset (rst_n=0, any time, including mid-transform): state=IDLE. All outputs 0. Counters and write pipeline cleared; no pending write survives.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on start=1. mode_in is latched into mode_out and the stage counter s is set to 0. start is ignored in every other state.
- Half-span h per stage:
  - NTT: h = N>>(s+1), so N/2 down to 1.
  - INTT: h = 1<<s, so 1 up to N/2.
  - With lh = log2(h):
    - g = k>>lh
    - rd_addr_a = (g<<(lh+1)) | (k & (h-1))
    - rd_addr_b = rd_addr_a | h
    - tw_addr = (N/(2h)) + g
  - All values are unsigned N_LOG-bit; tw_addr range is 1..N-1, and index 0 is never issued.
- RUN: rd_valid=1 each non-held cycle; butterfly counter k steps 0..N/2-1. After k=N/2-1 is issued, go to DRAIN with k reset to 0.
- DRAIN: rd_valid=0 for exactly BF_LAT non-held cycles. Then:
  - if s = N_LOG-1, go to DONE;
  - otherwise s+1 and go to RUN.
- DONE: done=1 for one cycle, busy=1, then IDLE with busy=0.
- Write pipeline: BF_LAT-deep shift register of {rd_valid, rd_addr_a, rd_addr_b}. A read issued in cycle t produces wr_valid with the same addresses in cycle t+BF_LAT. No write is ever reordered or dropped.
- hold=1: state, k, s, drain count and write pipeline all freeze. rd_valid and wr_valid are forced 0; address outputs keep their values. Issue resumes with the same k the cycle hold drops. hold is ignored in IDLE (start is still accepted) and in DONE.
- Timing without hold: start sampled at edge E0 → first rd_valid in cycle 1. Each stage takes N/2 + BF_LAT cycles. busy is high for N_LOG*(N/2+BF_LAT)+1 cycles, with done in the last of these.
- No back-to-back restart: start in the DONE cycle is ignored.

Test Plan:
- Reset: hold rst_n=0 with random inputs → all outputs 0. Assert rst_n=0 mid-RUN → next cycle busy=0, rd_valid=0, wr_valid=0, and no further writes occur.
- NTT (N_LOG=3, BF_LAT=2), start with mode_in=0 → the following (a,b,tw) sequence with gaps of 2 idle cycles between stages; done 18 cycles after the first rd_valid cycle; 19 busy cycles total.
  - Stage 0: (0,4,1)(1,5,1)(2,6,1)(3,7,1)
  - Stage 1: (0,2,2)(1,3,2)(4,6,3)(5,7,3)
  - Stage 2: (0,1,4)(2,3,5)(4,5,6)(6,7,7)
- INTT, mode_in=1, same parameters → mode_out=1 and the following (a,b,tw) sequence:
  - Stage 0: (0,1,4)(2,3,5)(4,5,6)(6,7,7)
  - Stage 1: (0,2,2)(1,3,2)(4,6,3)(5,7,3)
  - Stage 2: (0,4,1)(1,5,1)(2,6,1)(3,7,1)
- Write-back alignment: every wr_valid equals rd_valid delayed 2 cycles with identical addresses. Over the whole run, wr_valid count = 12 and the last write lands before done.
- Hold: assert hold for 3 cycles at k=2 of stage 1 → no strobes during the hold; (4,6,3) is issued the cycle after release; done is delayed by exactly 3 cycles. hold during DRAIN extends the gap by the hold length.
- start pulsed while busy and in the DONE cycle → ignored, mode_out unchanged. A new start in IDLE afterward runs a full transform.

Source files
------------

// File: rtl/ntt_bf_scheduler.sv
// Radix-2 butterfly sequencer for in-place NTT (Cooley-Tukey) / INTT (Gentleman-Sande).
// Issues one butterfly per cycle and replays its addresses as write-backs BF_LAT cycles later.
//
//   state | meaning
//   IDLE  | waiting for start; mode latched on acceptance
//   RUN   | issuing butterflies k = 0..N/2-1 of stage s
//   DRAIN | BF_LAT quiet cycles so stage s fully writes back
//   DONE  | one-cycle completion pulse
module ntt_bf_scheduler #(
   parameter int N_LOG  = 8,
   parameter int BF_LAT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode_in,
   input  logic             hold,
   output logic             busy,
   output logic             done,
   output logic             mode_out,
   output logic             rd_valid,
   output logic [N_LOG-1:0] rd_addr_a,
   output logic [N_LOG-1:0] rd_addr_b,
   output logic [N_LOG-1:0] tw_addr,
   output logic             wr_valid,
   output logic [N_LOG-1:0] wr_addr_a,
   output logic [N_LOG-1:0] wr_addr_b
);

   localparam int S_W = $clog2(N_LOG + 1);
   localparam int K_W = N_LOG - 1;
   localparam int D_W = $clog2(BF_LAT + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]       state;
   logic [K_W-1:0]   k;
   logic [S_W-1:0]   s;
   logic [D_W-1:0]   dcnt;
   logic             mode_q;
   logic             in_run;
   logic             stall;
   logic             issue;

   logic [S_W-1:0]   lh;
   logic [N_LOG-1:0] kx;
   logic [N_LOG-1:0] hh;
   logic [N_LOG-1:0] g;
   logic [N_LOG-1:0] addr_a;
   logic [N_LOG-1:0] addr_b;
   logic [N_LOG-1:0] addr_tw;

   logic [BF_LAT-1:0] pv;
   logic [N_LOG-1:0]  pa [BF_LAT];
   logic [N_LOG-1:0]  pb [BF_LAT];

   assign in_run = (state == ST_RUN);
   // hold only freezes the sequencer while a transform is actually in flight
   assign stall  = hold && (in_run || state == ST_DRAIN);
   assign issue  = in_run && !hold;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         k      <= '0;
         s      <= '0;
         dcnt   <= '0;
         mode_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state  <= ST_RUN;
                  mode_q <= mode_in;
                  s      <= '0;
                  k      <= '0;
               end
            end
            ST_RUN: begin
               if (!hold) begin
                  if (k == '1) begin
                     k     <= '0;
                     dcnt  <= D_W'(BF_LAT - 1);
                     state <= ST_DRAIN;
                  end else begin
                     k <= k + K_W'(1);
                  end
               end
            end
            ST_DRAIN: begin
               if (!hold) begin
                  if (dcnt == '0) begin
                     if (s == S_W'(N_LOG - 1)) begin
                        state <= ST_DONE;
                     end else begin
                        s     <= s + S_W'(1);
                        state <= ST_RUN;
                     end
                  end else begin
                     dcnt <= dcnt - D_W'(1);
                  end
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // lh = log2(half-span): shrinks per stage for NTT, grows for INTT
   always_comb begin
      lh      = mode_q ? s : (S_W'(N_LOG - 1) - s);
      kx      = N_LOG'(k);
      hh      = N_LOG'(1) << lh;
      g       = kx >> lh;
      addr_a  = (g << (lh + S_W'(1))) | (kx & (hh - N_LOG'(1)));
      addr_b  = addr_a | hh;
      addr_tw = (N_LOG'(1) << (S_W'(N_LOG - 1) - lh)) + g;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pv <= '0;
         for (int i = 0; i < BF_LAT; i++) begin
            pa[i] <= '0;
            pb[i] <= '0;
         end
      end else if (!stall) begin
         pv[0] <= issue;
         pa[0] <= rd_addr_a;
         pb[0] <= rd_addr_b;
         for (int i = 1; i < BF_LAT; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
            pb[i] <= pb[i-1];
         end
      end
   end

   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_DONE);
   assign mode_out  = mode_q;
   assign rd_valid  = issue;
   assign rd_addr_a = in_run ? addr_a  : '0;
   assign rd_addr_b = in_run ? addr_b  : '0;
   assign tw_addr   = in_run ? addr_tw : '0;
   assign wr_valid  = pv[BF_LAT-1] && !stall;
   assign wr_addr_a = pa[BF_LAT-1];
   assign wr_addr_b = pb[BF_LAT-1];

endmodule

// File: tb/tb_ntt_bf_scheduler.sv
// Bench for ntt_bf_scheduler (N=8, BF_LAT=2): random hold/start/mode stimulus checked against
// a cycle-slot model derived from the butterfly indexing formulas and the stage timing.
module tb_ntt_bf_scheduler;

   localparam int NL    = 3;
   localparam int BL    = 2;
   localparam int N     = 1 << NL;
   localparam int HALF  = N / 2;
   localparam int SL    = HALF + BL;
   localparam int TOTAL = NL * SL + 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       mode_in = 1'b0;
   logic       hold = 1'b0;
   logic       busy, done, mode_out, rd_valid, wr_valid;
   logic [2:0] rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b;

   int n_chk = 0;
   int n_fail = 0;

   ntt_bf_scheduler #(.N_LOG(NL), .BF_LAT(BL)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode_in(mode_in), .hold(hold),
      .busy(busy), .done(done), .mode_out(mode_out),
      .rd_valid(rd_valid), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
      .wr_valid(wr_valid), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // butterfly (a, b, tw) for stage st, butterfly kk, straight from the half-span definition
   function automatic logic [31:0] bfly(input bit md, input int st, input int kk);
      int h, g, a, b, tw;
      h  = md ? (1 << st) : (N >> (st + 1));
      g  = kk / h;
      a  = g * 2 * h + kk % h;
      b  = a + h;
      tw = N / (2 * h) + g;
      return 32'((a << 6) | (b << 3) | tw);
   endfunction

   function automatic bit is_rd_slot(input int t);
      return (t >= 1) && (t < TOTAL) && (((t - 1) % SL) < HALF);
   endfunction

   function automatic logic [31:0] all_outs();
      return 32'({busy, done, mode_out, rd_valid, rd_addr_a, rd_addr_b, tw_addr,
                  wr_valid, wr_addr_a, wr_addr_b});
   endfunction

   // hmode: 0 = no hold, 1 = directed holds (3 at stage-1 k=2, 2 in first drain), 2 = random
   task automatic run_xform(input bit md, input int hmode);
      int  act, streak, cyc, held, nrd, nwr, tn, st, pos, tw_;
      bit  hcur, active, seen;
      act = 0; streak = 0; cyc = 0; held = 0; nrd = 0; nwr = 0; seen = 0;
      @(posedge clk); #1;
      start = 1'b1; mode_in = md; hold = 1'($urandom_range(0, 1));
      while (!seen && cyc < 400) begin
         @(posedge clk); #1;
         tn = act + 1;
         case (hmode)
            1:       hcur = (tn == 9 && streak < 3) || (tn == 5 && streak < 2);
            2:       hcur = ($urandom_range(0, 4) == 0) && streak < 3;
            default: hcur = 1'b0;
         endcase
         streak  = hcur ? streak + 1 : 0;
         hold    = hcur;
         start   = ($urandom_range(0, 3) == 0) || (tn == TOTAL);
         mode_in = (tn == TOTAL) ? ~md : 1'($urandom);
         @(negedge clk);
         cyc++;
         active = !hcur || (tn == TOTAL);
         st  = (tn - 1) / SL;
         pos = (tn - 1) % SL;
         chk("busy", busy, 1);
         chk("mode_out", mode_out, md);
         if (active) begin
            act = tn;
            chk("rd_valid", rd_valid, is_rd_slot(tn));
            if (is_rd_slot(tn))
               chk("rd_addr", {rd_addr_a, rd_addr_b, tw_addr}, bfly(md, st, pos));
            tw_ = tn - BL;
            chk("wr_valid", wr_valid, is_rd_slot(tw_));
            if (is_rd_slot(tw_))
               chk("wr_addr", {wr_addr_a, wr_addr_b},
                   bfly(md, (tw_ - 1) / SL, (tw_ - 1) % SL) >> 3);
            chk("done", done, tn == TOTAL);
            if (tn == TOTAL) seen = 1;
         end else begin
            held++;
            chk("hold_rd", rd_valid, 0);
            chk("hold_wr", wr_valid, 0);
            chk("hold_done", done, 0);
            if (is_rd_slot(tn))
               chk("hold_addr", {rd_addr_a, rd_addr_b, tw_addr}, bfly(md, st, pos));
         end
         nrd += int'(rd_valid);
         nwr += int'(wr_valid);
      end
      chk("timeout", seen, 1);
      chk("rd_count", nrd, NL * HALF);
      chk("wr_count", nwr, NL * HALF);
      chk("busy_cycles", cyc, TOTAL + held);
      if (hmode == 1) chk("hold_delay", cyc, TOTAL + 5);
      @(posedge clk); #1;
      start = 1'b0; hold = 1'b0;
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_mode", mode_out, md);
      @(posedge clk); #1;
      @(negedge clk);
      chk("idle_outs", {busy, done, rd_valid, wr_valid}, 0);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         start = 1'($urandom); mode_in = 1'($urandom); hold = 1'($urandom);
         @(negedge clk);
         chk("reset_outs", all_outs(), 0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1; start = 1'b0; hold = 1'b0;
      @(negedge clk);
      chk("post_reset", all_outs(), 0);

      run_xform(1'b0, 0);
      run_xform(1'b1, 0);
      run_xform(1'b0, 1);
      run_xform(1'b1, 1);
      for (int r = 0; r < 6; r++) run_xform(1'($urandom), 2);

      // reset while stage 1 is in flight
      @(posedge clk); #1;
      start = 1'b1; mode_in = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("midrun_reset", all_outs(), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("after_reset", {busy, rd_valid, wr_valid}, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
